dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port data memory of the 16-bit RISC core between N_REQ requesters: the core's load/store port (port 0) plus a debug/loader port or a second master. Each cycle a round-robin picker grants at most one request. The chosen command is registered onto the memory port, and read data is routed back to the owner two cycles after the grant. It sits between the datapath's memory interface and the data-memory instance. The core uses `req[0] & ~gnt[0]` as its stall.

## Interface
- ADDR_W, 16, memory address width
- DATA_W, 16, memory data width
- N_REQ, 2, number of requesters (2..4)

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  N_REQ  per-port request, held until granted
- we  in  N_REQ  per-port write enable (1 = write, 0 = read), qualified by req
- addr  in  N_REQ*ADDR_W  per-port address, port k at bits [k*ADDR_W +: ADDR_W]
- wdata  in  N_REQ*DATA_W  per-port write data, same packing
- gnt  out  N_REQ  one-hot grant, combinational, same cycle as accepted req
- rvalid  out  N_REQ  one-hot read-data-valid, registered
- rdata  out  DATA_W  shared read data, valid where rvalid is set
- mem_en  out  1  memory access strobe, registered
- mem_we  out  1  memory write strobe, registered
- mem_addr  out  ADDR_W  registered
- mem_wdata  out  DATA_W  registered
- mem_rdata  in  DATA_W  synchronous-read memory output, valid the cycle after mem_en

## Operation
- **Priority pointer.** ptr (clog2(N_REQ) bits) names the highest-priority port. Search order is ptr, ptr+1, … mod N_REQ. The first port with req=1 gets gnt.
- **Pointer update.** On a grant to port k, ptr ← (k+1) mod N_REQ at the next edge. With no grant, ptr is unchanged.
- **Command stage.** On the edge ending the grant cycle:
  - mem_en←1; mem_we←we[k]; mem_addr←addr[k]; mem_wdata←wdata[k].
  - Otherwise mem_en←0 and mem_we←0. mem_addr and mem_wdata hold their values.
- **Read tracking.** A 2-stage owner pipeline of one-hot vector plus valid bit tracks each read. A write is issued but produces no rvalid.
- **Read return.** rdata is mem_rdata passed through. rvalid[k] is registered so it is high in the cycle mem_rdata returns.
- **Throughput.** One command per cycle. Back-to-back grants to the same port are allowed when no other port requests. Returns are strictly in issue order.
- **Requester rule.** addr, we and wdata must be stable while req is high and gnt is low. The cycle after gnt the requester may raise req for a new access or drop it.
- **Reset.**
  - While reset=1: gnt=0, mem_en=0, mem_we=0, rvalid=0, rdata undefined-but-unused, mem_addr=0, mem_wdata=0, ptr=0.
  - Reset mid-operation discards all in-flight reads: no rvalid ever appears for them.

## Timing
- Grant in cycle t. mem_en/mem_* are valid in t+1. For a read, rvalid[k] and rdata are valid in t+2.
- Read latency is 2 cycles from gnt. A write completes in memory at the end of t+1.
- A write granted in cycle t followed by a read of the same address granted in t+1 returns the new data, given a write-first or read-after-write-separated memory (sequential accesses).
- Simultaneous requests: exactly one gnt. Every other port waits at most N_REQ−1 grants.
- First cycle after reset release: port 0 wins ties.

## Structure
- Shared package risc_pkg:
  - ADDR_W and DATA_W defaults
  - function clog2
  - one-hot-to-index function
- Sub-module rr_picker:
  - Combinational: req vector + ptr → one-hot gnt + index + any.
  - Reusable by later arbiters (instruction-memory loader, peripheral bus).
- dmem_arbiter holds:
  - ptr register
  - command register stage
  - owner pipeline

## Test plan
- **Reset.** Hold reset 3 cycles with req=2'b11 → gnt=0, mem_en=0, rvalid=0 throughout. After release, port 0 is granted first.
- **Single read.** Port 0 reads 0x0010 (memory holds 0xBEEF) at cycle t → gnt=01 at t; mem_en=1, mem_addr=0x0010 at t+1; rvalid=01, rdata=0xBEEF at t+2.
- **Contention.** Both ports hold req with different addresses for 6 cycles → gnt sequence 01,10,01,10,01,10. rvalid follows the same order two cycles later.
- **Write then read.** Port 1 writes 0x1234 to 0x0004, then port 0 reads 0x0004 → mem_we=1 one cycle after the write gnt with no rvalid[1]. The read returns rdata=0x1234 with rvalid=01.
- **Streaming.** Port 0 alone reads 0x0000..0x0007 back-to-back → gnt[0] high 8 consecutive cycles, rvalid[0] high 8 consecutive cycles with data in address order.
- **Reset mid-read.** Port 1 read granted at t, reset asserted at t+1 → no rvalid at t+2. After release, ptr=0 and port 0 wins the first tie.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared definitions for the 16-bit RISC core memory subsystem.
// Holds default bus widths and small elaboration/decode helpers.
package risc_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Sized for up to four requesters; callers zero-extend narrower vectors.
    function automatic logic [1:0] onehot_to_idx(input logic [3:0] onehot);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (onehot[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr wins.
// Kept free of state so other arbiters can wrap it with their own pointer.
module rr_picker
    import risc_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int PTR_W = (N_REQ > 1) ? clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    always_comb begin
        logic [PTR_W-1:0] pos;
        pos = '0;
        gnt = '0;
        any = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            pos = PTR_W'((int'(ptr) + i) % N_REQ);
            if (!any && req[pos]) begin
                gnt[pos] = 1'b1;
                any      = 1'b1;
            end
        end
    end

    assign idx = PTR_W'(onehot_to_idx(4'(gnt)));

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between requesters.
// Grant is combinational, command is registered, read data returns two cycles after grant.
module dmem_arbiter
    import risc_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int N_REQ  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         we,
    input  logic [N_REQ*ADDR_W-1:0]  addr,
    input  logic [N_REQ*DATA_W-1:0]  wdata,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int PTR_W = (N_REQ > 1) ? clog2(N_REQ) : 1;

    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  gnt_idx;
    logic [PTR_W-1:0]  ptr_next;
    logic              gnt_any;
    logic [N_REQ-1:0]  req_live;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [N_REQ-1:0]  own1;
    logic              own1_v;

    // Masking requests during reset keeps gnt low without touching the picker.
    assign req_live = reset ? '0 : req;

    rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req (req_live),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    assign ptr_next = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt[k]) begin
                sel_we    = we[k];
                sel_addr  = addr[k*ADDR_W +: ADDR_W];
                sel_wdata = wdata[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            own1      <= '0;
            own1_v    <= 1'b0;
            rvalid    <= '0;
        end else begin
            if (gnt_any) begin
                ptr       <= ptr_next;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
            end
            mem_en <= gnt_any;
            mem_we <= gnt_any & sel_we;
            // Owner stage 1 travels with the command; stage 2 is rvalid itself.
            own1   <= (gnt_any && !sel_we) ? gnt : '0;
            own1_v <= gnt_any & ~sel_we;
            rvalid <= own1_v ? own1 : '0;
        end
    end

    assign rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: behavioural memory, request driver, grant/return model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [15:0] rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .N_REQ(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } op_t;

    typedef struct {
        int          port;
        logic [15:0] data;
        int          due;
    } sb_t;

    typedef struct {
        int          cyc;
        logic [1:0]  g;
    } glog_t;

    typedef struct {
        int          cyc;
        logic [1:0]  rv;
        logic [15:0] data;
    } rvlog_t;

    op_t    opq0[$];
    op_t    opq1[$];
    sb_t    sb[$];
    glog_t  glog[$];
    rvlog_t rvlog[$];

    logic [15:0] mem    [0:255];
    logic [15:0] shadow [0:255];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rv_cnt   = 0;
    logic rst_q  = 1'b1;
    logic [1:0] gnt_seen = '0;

    int          ptr_m = 0;
    logic        pend_v = 1'b0;
    logic        pend_we = 1'b0;
    logic [15:0] pend_addr = '0;
    logic [15:0] pend_wdata = '0;
    logic [15:0] exp_addr = '0;
    logic [15:0] exp_wdata = '0;
    logic [15:0] last_rd = '0;
    logic [1:0]  last_rv = '0;

    logic [1:0]  m_eg;
    bit          m_found;
    int          m_p;
    int          m_k;
    sb_t         m_e;
    glog_t       m_gl;
    rvlog_t      m_rl;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [15:0] init_val(input int i);
        if (i == 16) return 16'hBEEF;
        return 16'(i * 257) ^ 16'h5A00;
    endfunction

    // Synchronous-read, write-first memory.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr[7:0]] <= mem_wdata;
                mem_rdata          <= mem_wdata;
            end else begin
                mem_rdata <= mem[mem_addr[7:0]];
            end
        end
    end

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    // Request driver: hold each op until its grant is seen, then advance.
    always @(posedge clk) begin
        #1;
        if (gnt_seen[0] && opq0.size() > 0) void'(opq0.pop_front());
        if (gnt_seen[1] && opq1.size() > 0) void'(opq1.pop_front());
        if (opq0.size() > 0) begin
            req[0] = 1'b1; we[0] = opq0[0].we; addr[15:0] = opq0[0].addr; wdata[15:0] = opq0[0].wdata;
        end else begin
            req[0] = 1'b0; we[0] = 1'b0;
        end
        if (opq1.size() > 0) begin
            req[1] = 1'b1; we[1] = opq1[0].we; addr[31:16] = opq1[0].addr; wdata[31:16] = opq1[0].wdata;
        end else begin
            req[1] = 1'b0; we[1] = 1'b0;
        end
    end

    // Monitor and reference model, sampled mid-cycle.
    always @(negedge clk) begin
        gnt_seen = gnt;
        if (rst_q) begin
            ptr_m     = 0;
            sb.delete();
            pend_v    = 1'b0;
            exp_addr  = '0;
            exp_wdata = '0;
        end else if (pend_v) begin
            exp_addr  = pend_addr;
            exp_wdata = pend_wdata;
        end
        check("mem_en", 32'(mem_en), 32'(pend_v));
        check("mem_we", 32'(mem_we), 32'(pend_v & pend_we));
        check("mem_addr", 32'(mem_addr), 32'(exp_addr));
        check("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
        pend_v = 1'b0;

        if (rvalid != 2'b00 || (sb.size() > 0 && sb[0].due == cyc)) begin
            if (sb.size() == 0) begin
                check("rvalid_spurious", 32'(rvalid), 32'd0);
            end else begin
                m_e = sb.pop_front();
                check("rvalid_port", 32'(rvalid), 32'(1) << m_e.port);
                check("rdata", 32'(rdata), 32'(m_e.data));
                check("rlat", cyc, m_e.due);
            end
        end
        if (rvalid != 2'b00) begin
            rv_cnt++;
            last_rd = rdata;
            last_rv = rvalid;
            m_rl.cyc = cyc; m_rl.rv = rvalid; m_rl.data = rdata;
            rvlog.push_back(m_rl);
        end

        m_eg = '0;
        m_found = 1'b0;
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                m_p = (ptr_m + i) % 2;
                if (!m_found && req[m_p]) begin
                    m_eg[m_p] = 1'b1;
                    m_found   = 1'b1;
                end
            end
        end
        check("gnt", 32'(gnt), 32'(m_eg));
        if (gnt != 2'b00) begin
            m_gl.cyc = cyc; m_gl.g = gnt;
            glog.push_back(m_gl);
        end
        if (m_found) begin
            m_k        = m_eg[1] ? 1 : 0;
            ptr_m      = (m_k + 1) % 2;
            pend_v     = 1'b1;
            pend_we    = we[m_k];
            pend_addr  = addr[m_k*16 +: 16];
            pend_wdata = wdata[m_k*16 +: 16];
            if (we[m_k]) begin
                shadow[pend_addr[7:0]] = pend_wdata;
            end else begin
                m_e.port = m_k; m_e.data = shadow[pend_addr[7:0]]; m_e.due = cyc + 2;
                sb.push_back(m_e);
            end
        end
    end

    task automatic push_op(input int port, input logic w, input logic [15:0] a, input logic [15:0] d);
        op_t o;
        o.we = w; o.addr = a; o.wdata = d;
        if (port == 0) opq0.push_back(o);
        else           opq1.push_back(o);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((opq0.size() + opq1.size() + sb.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check(tag, opq0.size() + opq1.size() + sb.size(), 0);
    endtask

    initial begin
        int rel_cyc;
        int rv_before;
        int n;

        for (int i = 0; i < 256; i++) begin
            mem[i]    = init_val(i);
            shadow[i] = init_val(i);
        end
        mem_rdata = '0;
        reset = 1'b1;
        req = '0; we = '0; addr = '0; wdata = '0;

        // Reset with both ports requesting, then port 0 must win first.
        push_op(0, 1'b0, 16'h0010, 16'h0);
        push_op(1, 1'b0, 16'h0020, 16'h0);
        repeat (3) @(posedge clk);
        glog.delete();
        #1 reset = 1'b0;
        rel_cyc = cyc;
        wait_idle("rst_idle");
        check("rst_ngnt", glog.size(), 2);
        if (glog.size() >= 2) begin
            check("rst_first_gnt", 32'(glog[0].g), 32'h1);
            check("rst_first_cyc", glog[0].cyc, rel_cyc);
            check("rst_second_gnt", 32'(glog[1].g), 32'h2);
        end

        // Contention: six alternating grants on consecutive cycles.
        @(negedge clk);
        glog.delete();
        for (int i = 0; i < 3; i++) begin
            push_op(0, 1'b0, 16'(16'h0040 + i), 16'h0);
            push_op(1, 1'b0, 16'(16'h0050 + i), 16'h0);
        end
        wait_idle("cont_idle");
        check("cont_ngnt", glog.size(), 6);
        for (int i = 0; i < glog.size() && i < 6; i++) begin
            check("cont_gnt", 32'(glog[i].g), (i % 2 == 0) ? 32'h1 : 32'h2);
            if (i > 0) check("cont_b2b", glog[i].cyc, glog[i-1].cyc + 1);
        end

        // Single read of a known word.
        @(negedge clk);
        glog.delete();
        push_op(0, 1'b0, 16'h0010, 16'h0);
        wait_idle("single_idle");
        check("single_ngnt", glog.size(), 1);
        check("single_data", 32'(last_rd), 32'hBEEF);
        check("single_rv", 32'(last_rv), 32'h1);

        // Port 1 write immediately followed by port 0 read of the same word.
        @(negedge clk);
        push_op(1, 1'b1, 16'h0004, 16'h1234);
        push_op(0, 1'b0, 16'h0004, 16'h0);
        wait_idle("wr_rd_idle");
        check("wr_rd_data", 32'(last_rd), 32'h1234);
        check("wr_rd_rv", 32'(last_rv), 32'h1);

        // Streaming reads on port 0 alone.
        @(negedge clk);
        glog.delete();
        rvlog.delete();
        for (int i = 0; i < 8; i++) push_op(0, 1'b0, 16'(i), 16'h0);
        wait_idle("stream_idle");
        check("stream_ngnt", glog.size(), 8);
        check("stream_nrv", rvlog.size(), 8);
        for (int i = 0; i < glog.size() && i < 8; i++) begin
            check("stream_gnt", 32'(glog[i].g), 32'h1);
            if (i > 0) check("stream_gnt_b2b", glog[i].cyc, glog[i-1].cyc + 1);
        end
        for (int i = 0; i < rvlog.size() && i < 8; i++) begin
            check("stream_rdata", 32'(rvlog[i].data), (i == 4) ? 32'h1234 : 32'(init_val(i)));
            if (i > 0) check("stream_rv_b2b", rvlog[i].cyc, rvlog[i-1].cyc + 1);
        end

        // Reset arriving the cycle after a read grant; afterwards port 0 wins a tie.
        for (int p = 1; p >= 0; p--) begin
            @(negedge clk);
            push_op(p, 1'b0, 16'(16'h0030 + p), 16'h0);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!gnt[p] && n < 20);
            check("midrst_gnt", 32'(gnt[p]), 32'h1);
            rv_before = rv_cnt;
            @(posedge clk);
            #1 reset = 1'b1;
            @(negedge clk);
            push_op(0, 1'b0, 16'h0038, 16'h0);
            push_op(1, 1'b0, 16'h0039, 16'h0);
            glog.delete();
            @(posedge clk);
            @(negedge clk);
            check("midrst_norv", rv_cnt - rv_before, 0);
            @(posedge clk);
            #1 reset = 1'b0;
            wait_idle("midrst_idle");
            check("midrst_ngnt", glog.size(), 2);
            if (glog.size() >= 1) check("midrst_first_gnt", 32'(glog[0].g), 32'h1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

endmodule
